// File: rtl/cycle_sequencer.sv
// Multi-cycle phase controller for the MIPS datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, issues the write/load strobes and keeps retire/cycle counts.
module cycle_sequencer #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             halt_req,
   input  logic             ctl_reg_wr,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic             pc_en,
   output logic             reg_wr_en,
   output logic             mem_wr_en,
   output logic [2:0]       state,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6
   } state_e;

   localparam logic [3:0]       EXEC_LOAD = 4'(EXEC_CYCLES - 1);
   localparam logic [7:0]       MEM_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q, state_d;
   logic [3:0]       exec_cnt_q, exec_cnt_d;
   logic [7:0]       mem_cnt_q, mem_cnt_d;
   logic             fault_q, fault_d;
   logic             ir_load_q, pc_en_q, reg_wr_en_q, busy_q;
   logic [CNT_W-1:0] retire_cnt_q, cycle_cnt_q;

   // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      exec_cnt_d = exec_cnt_q;
      mem_cnt_d  = mem_cnt_q;
      fault_d    = fault_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            exec_cnt_d = EXEC_LOAD;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            if (exec_cnt_q != 4'd0) begin
               exec_cnt_d = exec_cnt_q - 4'd1;
            end else if (is_load || is_store) begin
               mem_cnt_d = 8'd0;
               state_d   = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = S_WB;
            end else if (mem_cnt_q == MEM_LAST) begin
               state_d = S_HALTED;
               fault_d = 1'b1;
            end else begin
               mem_cnt_d = mem_cnt_q + 8'd1;
            end
         end
         S_WB: begin
            if (halt_req)  state_d = S_HALTED;
            else if (!run) state_d = S_IDLE;
            else           state_d = S_FETCH;
         end
         S_HALTED: state_d = S_HALTED;
         // IDLE, and the unreachable code 7 which behaves as IDLE
         default:  state_d = run ? S_FETCH : S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         exec_cnt_q   <= 4'd0;
         mem_cnt_q    <= 8'd0;
         fault_q      <= 1'b0;
         ir_load_q    <= 1'b0;
         pc_en_q      <= 1'b0;
         reg_wr_en_q  <= 1'b0;
         busy_q       <= 1'b0;
         retire_cnt_q <= '0;
         cycle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         exec_cnt_q  <= exec_cnt_d;
         mem_cnt_q   <= mem_cnt_d;
         fault_q     <= fault_d;
         // Strobes are registered decodes of the state being entered
         ir_load_q   <= (state_d == S_FETCH);
         pc_en_q     <= (state_d == S_WB);
         reg_wr_en_q <= (state_d == S_WB) && ctl_reg_wr;
         busy_q      <= (state_d inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
         if (busy_q)           cycle_cnt_q  <= cycle_cnt_q + CNT_ONE;
         if (state_q == S_WB)  retire_cnt_q <= retire_cnt_q + CNT_ONE;
      end
   end

   // The data-memory write is the only Mealy strobe: it fires on the handshake cycle itself.
   assign mem_wr_en  = (state_q == S_MEM) && is_store && mem_ready;
   assign ir_load    = ir_load_q;
   assign pc_en      = pc_en_q;
   assign reg_wr_en  = reg_wr_en_q;
   assign busy       = busy_q;
   assign fault      = fault_q;
   assign state      = state_q;
   assign retire_cnt = retire_cnt_q;
   assign cycle_cnt  = cycle_cnt_q;

   a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ir_load, pc_en, mem_wr_en}));

endmodule
